// File: rtl/avalon_mem_arbiter.sv
// avalon_mem_arbiter
//   Two Avalon R/W slave ports share one single-port, 1-cycle-read-latency
//   32-bit memory. AV0 is the instruction-fetch side and AV1 the data side.
//   Each access runs IDLE -> ISSUE -> (CAPTURE) -> RESP -> IDLE. The port
//   that loses arbitration is held off with WaitRequest.
//   Configuration macro: MEM_ARB_FIXED_PRIO_EN
//     undefined (default): round-robin arbitration; AV0 wins the first tie.
//     defined            : fixed priority; AV0 wins every tie and there is
//                          no last-grant pointer.
module avalon_mem_arbiter #(
  parameter int ADDR_SEL_BITS = 6,
  localparam int AW = 30 - ADDR_SEL_BITS
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_AV0_SlaveSel,
  input  logic [AW-1:0] i_AV0_RegAddr,
  input  logic          i_AV0_Read,
  input  logic          i_AV0_Write,
  input  logic [31:0]   i_AV0_WriteData,
  input  logic [3:0]    i_AV0_ByteEnable,
  output logic [31:0]   o_AV0_ReadData,
  output logic          o_AV0_WaitRequest,
  input  logic          i_AV1_SlaveSel,
  input  logic [AW-1:0] i_AV1_RegAddr,
  input  logic          i_AV1_Read,
  input  logic          i_AV1_Write,
  input  logic [31:0]   i_AV1_WriteData,
  input  logic [3:0]    i_AV1_ByteEnable,
  output logic [31:0]   o_AV1_ReadData,
  output logic          o_AV1_WaitRequest,
  output logic [AW-1:0] o_Mem_Addr,
  output logic          o_Mem_Read,
  output logic          o_Mem_Write,
  output logic [31:0]   o_Mem_WriteData,
  output logic [3:0]    o_Mem_ByteEnable,
  input  logic [31:0]   i_Mem_ReadData
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t        state_q;
  logic          grant_q;      // port owning the current access
  logic          is_write_q;   // current access is a write
  logic          grant_d;      // winner if a grant is made this cycle
  logic [AW-1:0] addr_q;
  logic          mem_rd_q;
  logic          mem_wr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   rdata0_q;
  logic [31:0]   rdata1_q;

  logic          req0;
  logic          req1;
  logic [AW-1:0] sel_addr;
  logic          sel_write;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_be;

  assign req0 = i_AV0_SlaveSel & (i_AV0_Read | i_AV0_Write);
  assign req1 = i_AV1_SlaveSel & (i_AV1_Read | i_AV1_Write);

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: AV1 wins only when AV0 is not requesting.
  always_comb begin
    grant_d = ~req0;
  end
`else
  logic last_q;  // last granted port

  // Round-robin: on a tie the port that was not granted last wins.
  always_comb begin
    if (req0 && req1) begin
      grant_d = ~last_q;
    end else begin
      grant_d = req1;
    end
  end
`endif

  // Command of the winning port; a request with both Read and Write set is a write.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    sel_addr  = i_AV0_RegAddr;
    sel_write = i_AV0_Write;
    sel_wdata = i_AV0_WriteData;
    sel_be    = i_AV0_ByteEnable;
    if (grant_d) begin
      sel_addr  = i_AV1_RegAddr;
      sel_write = i_AV1_Write;
      sel_wdata = i_AV1_WriteData;
      sel_be    = i_AV1_ByteEnable;
    end
  end

  // Transaction FSM with registered memory command and per-port read data.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_q     <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register here sample pre-edge values, whatever the statement order.
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            state_q    <= ISSUE;
            grant_q    <= grant_d;
            is_write_q <= sel_write;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            be_q       <= sel_be;
            mem_rd_q   <= ~sel_write;
            mem_wr_q   <= sel_write;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q     <= grant_d;
`endif
          end
        end
        ISSUE: begin
          state_q <= is_write_q ? RESP : CAPTURE;
        end
        CAPTURE: begin
          state_q <= RESP;
          if (grant_q) begin
            rdata1_q <= i_Mem_ReadData;
          end else begin
            rdata0_q <= i_Mem_ReadData;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Requesting ports stall except the owner during its RESP cycle.
  assign o_AV0_WaitRequest = req0 & ~((state_q == RESP) && !grant_q);
  assign o_AV1_WaitRequest = req1 & ~((state_q == RESP) && grant_q);

  assign o_AV0_ReadData   = rdata0_q;
  assign o_AV1_ReadData   = rdata1_q;
  assign o_Mem_Addr       = addr_q;
  assign o_Mem_Read       = mem_rd_q;
  assign o_Mem_Write      = mem_wr_q;
  assign o_Mem_WriteData  = wdata_q;
  assign o_Mem_ByteEnable = be_q;

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Testbench for avalon_mem_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a transaction-timeline reference
// model (grant cycle, strobe cycle, response cycle) and a shadow memory.
module tb_avalon_mem_arbiter;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          av0_sel, av0_rd, av0_wr, av1_sel, av1_rd, av1_wr;
  logic [AW-1:0] av0_addr, av1_addr;
  logic [31:0]   av0_wd, av1_wd;
  logic [3:0]    av0_be, av1_be;
  logic [31:0]   rdata0, rdata1;
  logic          wait0, wait1;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr;
  logic [31:0]   mem_wd;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;

  avalon_mem_arbiter #(.ADDR_SEL_BITS(6)) dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_AV0_SlaveSel(av0_sel), .i_AV0_RegAddr(av0_addr), .i_AV0_Read(av0_rd),
    .i_AV0_Write(av0_wr), .i_AV0_WriteData(av0_wd), .i_AV0_ByteEnable(av0_be),
    .o_AV0_ReadData(rdata0), .o_AV0_WaitRequest(wait0),
    .i_AV1_SlaveSel(av1_sel), .i_AV1_RegAddr(av1_addr), .i_AV1_Read(av1_rd),
    .i_AV1_Write(av1_wr), .i_AV1_WriteData(av1_wd), .i_AV1_ByteEnable(av1_be),
    .o_AV1_ReadData(rdata1), .o_AV1_WaitRequest(wait1),
    .o_Mem_Addr(mem_addr), .o_Mem_Read(mem_rd), .o_Mem_Write(mem_wr),
    .o_Mem_WriteData(mem_wd), .o_Mem_ByteEnable(mem_be), .i_Mem_ReadData(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 5) return 32'hDEADBEEF;
    return {b, 8'hC3, ~b, 8'h5A};
  endfunction

  // Environment RAM: 16 words indexed by the low address bits, 1-cycle read latency.
  logic [31:0] ram [16];
  logic        mem_clear;
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
      mem_rdata <= '0;
    end else begin
      if (mem_rd) mem_rdata <= ram[mem_addr[3:0]];
      if (mem_wr)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[3:0]][8*b +: 8] <= mem_wd[8*b +: 8];
    end
  end

  // Behavioural masters.
  logic          m_sel [2];
  logic          m_rd  [2];
  logic          m_wr  [2];
  logic          m_hold[2];
  logic [AW-1:0] m_addr[2];
  logic [31:0]   m_wd  [2];
  logic [3:0]    m_be  [2];

  // Reference model state.
  logic [31:0]   shadow[16];
  int            cyc, free_at, strobe_at, resp_at, ptr, t_g;
  logic          t_wr;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_wd, t_data;
  logic [3:0]    e_be;

  int            ack_port[$];
  int            ack_at[$];
  logic [31:0]   ack_dat[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive();
    av0_sel = m_sel[0]; av0_rd = m_rd[0]; av0_wr = m_wr[0];
    av0_addr = m_addr[0]; av0_wd = m_wd[0]; av0_be = m_be[0];
    av1_sel = m_sel[1]; av1_rd = m_rd[1]; av1_wr = m_wr[1];
    av1_addr = m_addr[1]; av1_wd = m_wd[1]; av1_be = m_be[1];
  endtask

  task automatic clear_acks();
    ack_port.delete(); ack_at.delete(); ack_dat.delete();
  endtask

  // One clock cycle: drive, compare at negedge, advance the model, step to posedge+1.
  task automatic run_cycle();
    logic r0, r1, rsp;
    int   g, idx;
    drive();
    r0 = m_sel[0] & (m_rd[0] | m_wr[0]);
    r1 = m_sel[1] & (m_rd[1] | m_wr[1]);
    @(negedge clk);
    rsp = (cyc == resp_at);
    check("mem_read",  32'(mem_rd), 32'(cyc == strobe_at && !t_wr));
    check("mem_write", 32'(mem_wr), 32'(cyc == strobe_at && t_wr));
    check("mem_addr",  32'(mem_addr), 32'(e_addr));
    check("mem_wdata", mem_wd, e_wd);
    check("mem_be",    32'(mem_be), 32'(e_be));
    check("wait0",     32'(wait0), 32'(r0 && !(rsp && t_g == 0)));
    check("wait1",     32'(wait1), 32'(r1 && !(rsp && t_g == 1)));
    check("rdata0",    rdata0, (rsp && t_g == 0 && !t_wr) ? t_data : 32'h0);
    check("rdata1",    rdata1, (rsp && t_g == 1 && !t_wr) ? t_data : 32'h0);
    if (cyc >= free_at && (r0 || r1)) begin
      if (r0 && r1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        g = 0;
`else
        g = 1 - ptr;
`endif
      end else begin
        g = r1 ? 1 : 0;
      end
      ptr = g;
      t_g = g; t_wr = m_wr[g];
      e_addr = m_addr[g]; e_wd = m_wd[g]; e_be = m_be[g];
      idx = int'(e_addr[3:0]);
      strobe_at = cyc + 1;
      resp_at   = cyc + (t_wr ? 2 : 3);
      free_at   = resp_at + 1;
      if (t_wr) begin
        for (int b = 0; b < 4; b++)
          if (e_be[b]) shadow[idx][8*b +: 8] = e_wd[8*b +: 8];
      end else begin
        t_data = shadow[idx];
      end
    end
    if (r0 && !wait0) begin
      ack_port.push_back(0); ack_at.push_back(cyc); ack_dat.push_back(rdata0);
      if (!m_hold[0]) begin m_rd[0] = 1'b0; m_wr[0] = 1'b0; end
    end
    if (r1 && !wait1) begin
      ack_port.push_back(1); ack_at.push_back(cyc); ack_dat.push_back(rdata1);
      if (!m_hold[1]) begin m_rd[1] = 1'b0; m_wr[1] = 1'b0; end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // Hold reset for n cycles, checking the cleared outputs, then restart the model.
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      drive();
      @(negedge clk);
      check("rst_mem_read",  32'(mem_rd), 32'h0);
      check("rst_mem_write", 32'(mem_wr), 32'h0);
      check("rst_mem_addr",  32'(mem_addr), 32'h0);
      check("rst_mem_wdata", mem_wd, 32'h0);
      check("rst_mem_be",    32'(mem_be), 32'h0);
      check("rst_rdata0",    rdata0, 32'h0);
      check("rst_rdata1",    rdata1, 32'h0);
      @(posedge clk); #1;
      cyc++;
    end
    rst = 1'b0;
    ptr = 1; strobe_at = -1; resp_at = -1; free_at = cyc;
    e_addr = '0; e_wd = '0; e_be = '0; t_wr = 1'b0; t_g = 0;
  endtask

  function automatic int ack_port_at(input int k);
    return (k < ack_port.size()) ? ack_port[k] : -1;
  endfunction

  function automatic int ack_cyc_at(input int k);
    return (k < ack_at.size()) ? ack_at[k] : -1;
  endfunction

  initial begin
    int start, k, op;
    rst = 1'b1; mem_clear = 1'b1;
    for (int n = 0; n < 2; n++) begin
      m_sel[n] = 1'b0; m_rd[n] = 1'b0; m_wr[n] = 1'b0; m_hold[n] = 1'b0;
      m_addr[n] = '0; m_wd[n] = '0; m_be[n] = '0;
    end
    for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
    cyc = 0; ptr = 1; t_g = 0; t_wr = 1'b0; t_data = '0;
    strobe_at = -1; resp_at = -1; free_at = 0;
    e_addr = '0; e_wd = '0; e_be = '0;
    drive();
    @(posedge clk); #1;
    mem_clear = 1'b0;
    cyc++;
    do_reset(2);

    // AV0 read of address 0x05.
    clear_acks();
    m_sel[0] = 1'b1; m_rd[0] = 1'b1; m_addr[0] = AW'(5);
    start = cyc;
    repeat (6) run_cycle();
    check("t1_acks",     32'(ack_port.size()), 32'd1);
    check("t1_port",     32'(ack_port_at(0)), 32'd0);
    check("t1_latency",  32'(ack_cyc_at(0) - start), 32'd3);
    check("t1_data",     (ack_dat.size() > 0) ? ack_dat[0] : 32'hX, 32'hDEADBEEF);

    // AV1 write of 0x12345678 to address 0x10, lanes 0-1.
    clear_acks();
    m_sel[1] = 1'b1; m_wr[1] = 1'b1; m_addr[1] = AW'(16);
    m_wd[1] = 32'h12345678; m_be[1] = 4'h3;
    start = cyc;
    repeat (5) run_cycle();
    check("t2_acks",     32'(ack_port.size()), 32'd1);
    check("t2_port",     32'(ack_port_at(0)), 32'd1);
    check("t2_latency",  32'(ack_cyc_at(0) - start), 32'd2);
    check("t2_rdata",    (ack_dat.size() > 0) ? ack_dat[0] : 32'hX, 32'h0);

    // Both ports read continuously from reset: eight back-to-back transactions.
    do_reset(1);
    clear_acks();
    m_sel[0] = 1'b1; m_rd[0] = 1'b1; m_hold[0] = 1'b1; m_addr[0] = AW'(3);
    m_sel[1] = 1'b1; m_rd[1] = 1'b1; m_hold[1] = 1'b1; m_addr[1] = AW'(16 * 9 + 9);
    start = cyc;
    repeat (32) run_cycle();
    check("t4_acks", 32'(ack_port.size()), 32'd8);
    for (int j = 0; j < 8; j++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      check($sformatf("t4_port%0d", j), 32'(ack_port_at(j)), 32'd0);
`else
      check($sformatf("t4_port%0d", j), 32'(ack_port_at(j)), 32'(j % 2));
`endif
      check($sformatf("t4_cycle%0d", j), 32'(ack_cyc_at(j) - start), 32'(3 + 4 * j));
    end
    for (int n = 0; n < 2; n++) begin
      m_rd[n] = 1'b0; m_hold[n] = 1'b0; m_sel[n] = 1'b0;
    end
    repeat (2) run_cycle();

    // Reset during CAPTURE of an AV1 read, then full re-service.
    clear_acks();
    m_sel[1] = 1'b1; m_rd[1] = 1'b1; m_wr[1] = 1'b0; m_addr[1] = AW'(7);
    repeat (2) run_cycle();
    do_reset(1);
    start = cyc;
    repeat (6) run_cycle();
    check("t5_acks",    32'(ack_port.size()), 32'd1);
    check("t5_port",    32'(ack_port_at(0)), 32'd1);
    check("t5_latency", 32'(ack_cyc_at(0) - start), 32'd3);
    check("t5_data",    (ack_dat.size() > 0) ? ack_dat[0] : 32'hX, shadow[7]);

    // Read asserted without SlaveSel is not a request.
    clear_acks();
    m_sel[0] = 1'b0; m_rd[0] = 1'b1; m_addr[0] = AW'(5);
    repeat (5) run_cycle();
    check("t6_acks", 32'(ack_port.size()), 32'd0);
    m_rd[0] = 1'b0;

    // Random traffic on both ports.
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!(m_sel[n] && (m_rd[n] || m_wr[n]))) begin
          k = int'($urandom_range(0, 5));
          if (k < 2) begin
            op = int'($urandom_range(0, 2));
            m_sel[n]  = 1'b1;
            m_rd[n]   = (op != 1);
            m_wr[n]   = (op != 0);
            m_addr[n] = AW'($urandom);
            m_wd[n]   = $urandom;
            m_be[n]   = 4'($urandom);
          end else begin
            m_sel[n] = 1'b0;
            m_rd[n]  = 1'($urandom_range(0, 1));
            m_wr[n]  = 1'b0;
          end
        end
      end
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
